// File: rtl/alu_seq.sv
// Sequencer that drives a 16-bit ALU for one pass (16-bit ops) or two chained passes (32-bit ops).
// Done follows the start edge by 2 or 3 cycles; start is only taken in IDLE, so there is no backpressure.
module alu_seq #(
  parameter logic [4:0] NOP_SEL = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] op,
  input  logic       wide,
  input  logic       use_carry,
  input  logic       clr_flags,
  input  logic       alu_carry_out,
  input  logic       alu_zero,
  output logic [4:0] alu_select,
  output logic       alu_enable,
  output logic       alu_carry_in,
  output logic       lo_sel,
  output logic       res_lo_we,
  output logic       res_hi_we,
  output logic       busy,
  output logic       done,
  output logic       flag_c,
  output logic       flag_z
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       wide_q, wide_d;
  logic       use_carry_q, use_carry_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       chain_c_q, chain_c_d;
  logic       zero_lo_q, zero_lo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      wide_q      <= 1'b0;
      use_carry_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      chain_c_q   <= 1'b0;
      zero_lo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wide_q      <= wide_d;
      use_carry_q <= use_carry_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      chain_c_q   <= chain_c_d;
      zero_lo_q   <= zero_lo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wide_d       = wide_q;
    use_carry_d  = use_carry_q;
    flag_c_d     = flag_c_q;
    flag_z_d     = flag_z_q;
    chain_c_d    = chain_c_q;
    zero_lo_d    = zero_lo_q;
    alu_select   = NOP_SEL;
    alu_enable   = 1'b0;
    alu_carry_in = 1'b0;
    lo_sel       = 1'b1;
    res_lo_we    = 1'b0;
    res_hi_we    = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Clear lands on the same edge as the latch, so a LO pass started
        // alongside it already sees the cleared carry.
        if (clr_flags) begin
          flag_c_d = 1'b0;
          flag_z_d = 1'b0;
        end
        if (start) begin
          op_d        = op;
          wide_d      = wide;
          use_carry_d = use_carry;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        alu_enable   = 1'b1;
        alu_select   = op_q;
        res_lo_we    = 1'b1;
        alu_carry_in = use_carry_q & flag_c_q;
        chain_c_d    = alu_carry_out;
        zero_lo_d    = alu_zero;
        if (wide_q) begin
          state_d = S_HI;
        end else begin
          flag_c_d = alu_carry_out;
          flag_z_d = alu_zero;
          state_d  = S_DONE;
        end
      end
      S_HI: begin
        alu_enable   = 1'b1;
        alu_select   = op_q;
        lo_sel       = 1'b0;
        res_hi_we    = 1'b1;
        alu_carry_in = chain_c_q;
        flag_c_d     = alu_carry_out;
        flag_z_d     = zero_lo_q & alu_zero;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 The block SHALL have parameter NOP_SEL, default 5'd0, meaning the alu_select value driven whenever no pass is active.

Interface
REQ-002 The block SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have start  input  1  operation request, sampled only in IDLE.
REQ-005 The block SHALL have op  input  5  ALU select code for the requested operation.
REQ-006 The block SHALL have wide  input  1  1 = 32-bit operation (two passes), 0 = 16-bit (one pass).
REQ-007 The block SHALL have use_carry  input  1  1 = first-pass carry_in taken from flag_c, 0 = first-pass carry_in is 0.
REQ-008 The block SHALL have clr_flags  input  1  synchronous clear of flag_c and flag_z, honoured only in IDLE.
REQ-009 The block SHALL have alu_carry_out  input  1  carry output of the ALU.
REQ-010 The block SHALL have alu_zero  input  1  zero flag of the ALU.
REQ-011 The block SHALL have alu_select  output  5  ALU operation select.
REQ-012 The block SHALL have alu_enable  output  1  ALU result-drive enable.
REQ-013 The block SHALL have alu_carry_in  output  1  ALU carry input.
REQ-014 The block SHALL have lo_sel  output  1  operand/result half select: 1 = low word, 0 = high word.
REQ-015 The block SHALL have res_lo_we, res_hi_we  output  1 each  result-register write strobes, low and high words.
REQ-016 The block SHALL have busy, done  output  1 each  operation in progress; one-cycle completion pulse.
REQ-017 The block SHALL have flag_c, flag_z  output  1 each  registered carry and zero flags.

Function
REQ-018 The block SHALL implement the states IDLE, LO, HI and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch op, wide and use_carry and SHALL go to LO on that edge; start outside IDLE SHALL be ignored.
REQ-020 LO SHALL drive the following for exactly one cycle: alu_enable=1, alu_select=latched op, lo_sel=1, res_lo_we=1, alu_carry_in=(use_carry_q ? flag_c : 0).
REQ-021 At the end of LO, the block SHALL capture alu_carry_out into an internal chain carry and alu_zero into an internal zero_lo register.
REQ-022 From LO, the block SHALL go to HI if wide_q=1, else to DONE.
REQ-023 HI SHALL drive the following for exactly one cycle: alu_enable=1, alu_select=latched op, lo_sel=0, res_hi_we=1, alu_carry_in=chain carry.
REQ-024 Flag update SHALL occur on the edge ending the final pass:
- 16-bit: flag_c <= alu_carry_out and flag_z <= alu_zero at the end of LO.
- 32-bit: flag_c <= alu_carry_out and flag_z <= (zero_lo & alu_zero) at the end of HI.
- Flags SHALL hold at all other times.
REQ-025 DONE SHALL assert done=1 for one cycle and SHALL return to IDLE unconditionally; start during DONE SHALL be ignored.
REQ-026 busy SHALL be 1 in LO, HI and DONE, and 0 in IDLE.
REQ-027 Latency SHALL be start edge to done high = 2 cycles (16-bit) or 3 cycles (32-bit); back-to-back throughput SHALL be one operation per 3 cycles (16-bit) or 4 cycles (32-bit).
REQ-028 Outside LO and HI, the block SHALL drive alu_enable=0, alu_select=NOP_SEL, alu_carry_in=0, lo_sel=1, res_lo_we=0 and res_hi_we=0.
REQ-029 clr_flags and start asserted together in IDLE SHALL both take effect: flags clear, and the operation's LO pass sees flag_c=0.
REQ-030 clr_flags outside IDLE SHALL be ignored.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, and SHALL clear busy, done, flag_c, flag_z, chain carry, zero_lo and the latched op/wide/use_carry, independent of clk.
REQ-032 reset asserted mid-operation SHALL abort it with no further write strobes and no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-033 The bench SHALL cover a 16-bit op: op=5'd3, wide=0, use_carry=0, ALU model returns carry=1, zero=0 -> one LO cycle with alu_select=3 and res_lo_we=1, done 2 cycles after start, flag_c=1, flag_z=0.
REQ-034 The bench SHALL cover 32-bit carry chaining: wide=1, LO carry_out=1, zero=1; HI zero=1 -> HI drives alu_carry_in=1 and res_hi_we=1, done at cycle 3, flag_z=1.
REQ-035 The bench SHALL cover 32-bit zero combination: LO zero=1, HI zero=0 -> flag_z=0.
REQ-036 The bench SHALL cover use_carry: flag_c=1, then start with use_carry=1 -> LO alu_carry_in=1; the same with clr_flags=1 in the start cycle -> alu_carry_in=0.
REQ-037 The bench SHALL cover start held high continuously -> operations accepted only from IDLE (every 3rd cycle for 16-bit), with no extra passes.
REQ-038 The bench SHALL cover reset asserted during HI -> outputs return to reset values immediately, no done pulse, and flags=0.
